// File: rtl/regfile_wb.sv
// Two-read, one-write 32x32 MIPS register file with $zero hardwiring and async reset.
// Optional same-cycle write-through bypass on both read ports: define REGFILE_BYPASS_EN.
module regfile_wb #(
   parameter logic [31:0] SP_RESET = 32'h0000_0000,
   parameter logic [31:0] GP_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWrite,
   input  logic [4:0]  wr_reg,
   input  logic [31:0] wr_data,
   input  logic [4:0]  rd_reg1,
   input  logic [4:0]  rd_reg2,
   output logic [31:0] out1,
   output logic [31:0] out2
);

   logic [31:0] regs [1:31];
   logic [31:0] rf_view [32];
   logic        wr_en;

   function automatic logic [31:0] reset_value(input logic [4:0] idx);
      case (idx)
         5'd28:   reset_value = GP_RESET;
         5'd29:   reset_value = SP_RESET;
         default: reset_value = 32'h0000_0000;
      endcase
   endfunction

   // Writes to $zero are dropped here so the array never needs an entry 0.
   assign wr_en = RegWrite && (wr_reg != 5'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= reset_value(5'(i));
         end
      end else if (wr_en) begin
         regs[wr_reg] <= wr_data;
      end
   end

   always_comb begin
      rf_view[0] = 32'h0000_0000;
      for (int i = 1; i < 32; i++) begin
         rf_view[i] = regs[i];
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Write-through: a WB-stage write is forwarded to ID reads before the edge.
   logic byp1;
   logic byp2;

   assign byp1 = !rst && wr_en && (rd_reg1 == wr_reg);
   assign byp2 = !rst && wr_en && (rd_reg2 == wr_reg);

   always_comb begin
      out1 = byp1 ? wr_data : rf_view[rd_reg1];
      out2 = byp2 ? wr_data : rf_view[rd_reg2];
   end
`else
   always_comb begin
      out1 = rf_view[rd_reg1];
      out2 = rf_view[rd_reg2];
   end
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: expectations queued at stimulus time, popped at sample time.
module tb_regfile_wb;

   localparam logic [31:0] SP = 32'h0000_3FFC;
   localparam logic [31:0] GP = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        RegWrite;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic [4:0]  rd_reg1;
   logic [4:0]  rd_reg2;
   logic [31:0] out1;
   logic [31:0] out2;

   typedef struct {
      string       name;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } sb_t;

   sb_t         sb[$];
   int          checks;
   int          failures;
   logic [31:0] model [32];

   regfile_wb #(.SP_RESET(SP), .GP_RESET(GP)) dut (
      .clk(clk), .rst(rst), .RegWrite(RegWrite), .wr_reg(wr_reg), .wr_data(wr_data),
      .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .out1(out1), .out2(out2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required TB_RESULT before it");
      $fatal(1, "watchdog");
   end

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sb_t e;
      RegWrite = 1'b0; wr_reg = 5'd0; wr_data = '0; rd_reg1 = 5'd0; rd_reg2 = 5'd28;
      step();
      #3 rst = 1'b1;
      #1;
      sb.push_back('{name:"reset_r0_r28", exp1:32'h0, exp2:GP});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      rd_reg1 = 5'd29; rd_reg2 = 5'd31;
      #1;
      sb.push_back('{name:"reset_r29_r31", exp1:SP, exp2:32'h0});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      // Registers hold reset values across an edge with a write pending.
      RegWrite = 1'b1; wr_reg = 5'd29; wr_data = 32'h1111_2222;
      step();
      sb.push_back('{name:"reset_hold_r29", exp1:SP, exp2:32'h0});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      RegWrite = 1'b0;
      #3 rst = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? SP : ((i == 28) ? GP : 32'h0);
   endtask

   task automatic test_zero_write();
      sb_t e;
      RegWrite = 1'b1; wr_reg = 5'd0; wr_data = 32'hDEAD_BEEF; rd_reg1 = 5'd0; rd_reg2 = 5'd0;
      #1;
      sb.push_back('{name:"zero_before_edge", exp1:32'h0, exp2:32'h0});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      step();
      sb.push_back('{name:"zero_after_edge", exp1:32'h0, exp2:32'h0});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      RegWrite = 1'b0;
   endtask

   task automatic test_write_dual_read();
      sb_t e;
      RegWrite = 1'b1; wr_reg = 5'd8; wr_data = 32'h1234_5678; rd_reg1 = 5'd8; rd_reg2 = 5'd9;
      step();
      model[8] = 32'h1234_5678;
      sb.push_back('{name:"dual_after_first", exp1:model[8], exp2:model[9]});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      wr_reg = 5'd9; wr_data = 32'hFFFF_0001;
      step();
      model[9] = 32'hFFFF_0001;
      RegWrite = 1'b0;
      #1;
      sb.push_back('{name:"dual_read_8_9", exp1:32'h1234_5678, exp2:32'hFFFF_0001});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      rd_reg1 = 5'd9;
      #1;
      sb.push_back('{name:"same_addr_both", exp1:32'hFFFF_0001, exp2:32'hFFFF_0001});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
   endtask

   task automatic test_link_write();
      sb_t e;
      RegWrite = 1'b1; wr_reg = 5'd31; wr_data = 32'h0040_0008; rd_reg1 = 5'd31; rd_reg2 = 5'd8;
      #1;
      sb.push_back('{name:"link_before_edge", exp1:(BYPASS ? 32'h0040_0008 : model[31]), exp2:model[8]});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      step();
      model[31] = 32'h0040_0008;
      RegWrite = 1'b0;
      #1;
      sb.push_back('{name:"link_after_edge", exp1:32'h0040_0008, exp2:model[8]});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
   endtask

   task automatic test_no_write();
      sb_t e;
      RegWrite = 1'b1; wr_reg = 5'd5; wr_data = 32'h0000_0011;
      step();
      model[5] = 32'h0000_0011;
      RegWrite = 1'b0; wr_data = 32'hAAAA_AAAA; rd_reg1 = 5'd5; rd_reg2 = 5'd5;
      #1;
      sb.push_back('{name:"nowrite_before_edge", exp1:model[5], exp2:model[5]});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      step();
      sb.push_back('{name:"nowrite_after_edge", exp1:32'h0000_0011, exp2:32'h0000_0011});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
   endtask

   task automatic test_reset_vs_write();
      sb_t e;
      RegWrite = 1'b1; wr_reg = 5'd3; wr_data = 32'h0000_00FF; rd_reg1 = 5'd3; rd_reg2 = 5'd8;
      #2 rst = 1'b1;
      step();
      #3 rst = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? SP : ((i == 28) ? GP : 32'h0);
      #1;
      sb.push_back('{name:"rstwr_lost", exp1:(BYPASS ? 32'h0000_00FF : 32'h0), exp2:32'h0});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      RegWrite = 1'b0; rd_reg2 = 5'd29;
      #1;
      sb.push_back('{name:"rstwr_reg3_zero", exp1:32'h0, exp2:SP});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
      RegWrite = 1'b1;
      step();
      model[3] = 32'h0000_00FF;
      RegWrite = 1'b0;
      #1;
      sb.push_back('{name:"rstwr_first_write", exp1:32'h0000_00FF, exp2:SP});
      e = sb.pop_front(); checks++;
      if (out1 !== e.exp1 || out2 !== e.exp2) begin
         failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
      end
   endtask

   task automatic test_back_to_back();
      sb_t e;
      logic [31:0] d;
      for (int i = 1; i < 32; i++) begin
         d = {$urandom_range(0, 65535), 16'(i * 3 + 1)};
         RegWrite = 1'b1; wr_reg = 5'(i); wr_data = d;
         rd_reg1 = 5'(i); rd_reg2 = 5'(i - 1);
         step();
         model[i] = d;
         sb.push_back('{name:$sformatf("b2b_wr_r%0d", i), exp1:model[i], exp2:model[i - 1]});
         e = sb.pop_front(); checks++;
         if (out1 !== e.exp1 || out2 !== e.exp2) begin
            failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
         end
      end
      RegWrite = 1'b0;
      for (int i = 0; i < 32; i += 2) begin
         rd_reg1 = 5'(i); rd_reg2 = 5'(31 - i);
         #1;
         sb.push_back('{name:$sformatf("b2b_rd_r%0d", i), exp1:model[i], exp2:model[31 - i]});
         e = sb.pop_front(); checks++;
         if (out1 !== e.exp1 || out2 !== e.exp2) begin
            failures++; $display("FAIL %s: got %h/%h required %h/%h", e.name, out1, out2, e.exp1, e.exp2);
         end
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b0; RegWrite = 1'b0; wr_reg = '0; wr_data = '0; rd_reg1 = '0; rd_reg2 = '0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      test_reset();
      test_zero_write();
      test_write_dual_read();
      test_link_write();
      test_no_write();
      test_reset_vs_write();
      test_back_to_back();
      if (sb.size() != 0) begin
         checks++; failures++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
